// File: rtl/and_mask_arbiter_if.sv
// rtl/and_mask_arbiter_if.sv - request/response bundle between clients and the shared AND arbiter
interface and_mask_arbiter_if #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4
);
  localparam int ID_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]       req_valid;
  logic [REQUESTERS-1:0]       req_ready;
  logic [REQUESTERS*WIDTH-1:0] req_a;
  logic [REQUESTERS*WIDTH-1:0] req_b;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [WIDTH-1:0]            rsp_data;
  logic [ID_W-1:0]             rsp_id;
  logic [7:0]                  grant_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, grant_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, grant_count
  );
endinterface

// File: rtl/and_mask_arbiter.sv
// rtl/and_mask_arbiter.sv - round-robin arbiter feeding one shared registered a & b stage
module and_mask_arbiter #(
  parameter int WIDTH      = 16,
  parameter int REQUESTERS = 4
) (
  input logic                clk,
  input logic                rst,
  and_mask_arbiter_if.slave  bus
);
  localparam int ID_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] masked;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [7:0]       grant_count_q;

  // The slot is free when empty or when the held result drains this cycle.
  assign accept   = !rsp_valid_q || bus.rsp_ready;
  assign transfer = !rst && accept && grant_any;

  // Search starts just past the last winner; the modulo keeps non-power-of-two
  // counts from ever landing on an index at or above REQUESTERS.
  always_comb begin
    int              cand;
    logic [ID_W-1:0] cand_idx;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      cand     = (int'(last_grant) + k) % REQUESTERS;
      cand_idx = ID_W'(cand);
      if (!grant_any && bus.req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (transfer) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (ID_W'(i) == grant_idx) begin
        masked = bus.req_a[i*WIDTH +: WIDTH] & bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      last_grant    <= ID_W'(REQUESTERS - 1);
      grant_count_q <= 8'd0;
    end else if (transfer) begin
      rsp_valid_q   <= 1'b1;
      rsp_data_q    <= masked;
      rsp_id_q      <= grant_idx;
      last_grant    <= grant_idx;
      grant_count_q <= grant_count_q + 8'd1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.grant_count = grant_count_q;
endmodule

// File: tb/tb_and_mask_arbiter.sv
// tb/tb_and_mask_arbiter.sv - directed self-checking bench for and_mask_arbiter
module tb_and_mask_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   passes;
  int   exp_id;

  and_mask_arbiter_if #(.WIDTH(16), .REQUESTERS(4)) bus ();

  and_mask_arbiter #(.WIDTH(16), .REQUESTERS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  initial begin
    total  = 0;
    passes = 0;
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // reset with every client requesting
    tick();
    check("rst_ready_0", bus.req_ready, 4'b0000);
    tick();
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_count", bus.grant_count, 0);
    check("rst_ready_1", bus.req_ready, 4'b0000);
    rst = 1'b0;
    #1;
    check("first_grant", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0000;
    #1;
    check("withdraw_ready", bus.req_ready, 4'b0000);
    tick();
    check("idle_valid", bus.rsp_valid, 0);
    check("idle_count", bus.grant_count, 0);

    // single client
    set_op(2, 16'hF0F0, 16'h3C3C);
    bus.req_valid = 4'b0100;
    #1;
    check("single_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0000;
    check("single_valid", bus.rsp_valid, 1);
    check("single_data", bus.rsp_data, 16'h3030);
    check("single_id", bus.rsp_id, 2);
    check("single_count", bus.grant_count, 1);

    // round robin, pointer currently at 2
    for (int i = 0; i < 4; i++) set_op(i, 16'hFFFF, 16'(i + 1));
    bus.req_valid = 4'b1111;
    exp_id = 2;
    for (int k = 0; k < 8; k++) begin
      exp_id = (exp_id + 1) % 4;
      #1;
      check("rr_ready", bus.req_ready, 32'(1 << exp_id));
      tick();
      check("rr_id", bus.rsp_id, exp_id);
      check("rr_data", bus.rsp_data, exp_id + 1);
    end
    check("rr_count", bus.grant_count, 9);
    bus.req_valid = 4'b0000;

    // backpressure
    set_op(0, 16'h00FF, 16'h00AA);
    bus.req_valid = 4'b0001;
    #1;
    check("bp_fill_ready", bus.req_ready, 4'b0001);
    tick();
    check("bp_fill_data", bus.rsp_data, 16'h00AA);
    check("bp_fill_count", bus.grant_count, 10);
    bus.rsp_ready = 1'b0;
    set_op(0, 16'h0F0F, 16'hFFFF);
    set_op(1, 16'hFFFF, 16'h0055);
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_ready", bus.req_ready, 4'b0000);
      tick();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, 16'h00AA);
      check("bp_count", bus.grant_count, 10);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.req_ready, 4'b0010);
    tick();
    check("bp_b2b_data1", bus.rsp_data, 16'h0055);
    check("bp_b2b_id1", bus.rsp_id, 1);
    check("bp_b2b_count1", bus.grant_count, 11);
    bus.req_valid = 4'b0001;
    #1;
    check("bp_next_ready", bus.req_ready, 4'b0001);
    tick();
    check("bp_b2b_valid", bus.rsp_valid, 1);
    check("bp_b2b_data0", bus.rsp_data, 16'h0F0F);
    check("bp_b2b_id0", bus.rsp_id, 0);
    check("bp_b2b_count0", bus.grant_count, 12);
    bus.req_valid = 4'b0000;
    tick();
    check("drain_valid", bus.rsp_valid, 0);
    check("drain_count", bus.grant_count, 12);

    // counter wrap over 257 transfers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 16'hFFFF, 16'(i + 1));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 257; k++) begin
      tick();
      check("wrap_id", bus.rsp_id, k % 4);
      check("wrap_data", bus.rsp_data, (k % 4) + 1);
    end
    check("wrap_count", bus.grant_count, 1);
    bus.req_valid = 4'b0010;
    tick();
    check("pre_rst_id", bus.rsp_id, 1);
    check("pre_rst_count", bus.grant_count, 2);

    // mid-operation reset with a stalled result
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0000;
    tick();
    check("stall_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    check("midrst_ready", bus.req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    check("midrst_valid", bus.rsp_valid, 0);
    check("midrst_count", bus.grant_count, 0);
    #1;
    check("midrst_grant", bus.req_ready, 4'b0010);
    bus.rsp_ready = 1'b1;
    tick();
    check("post_rst_id", bus.rsp_id, 1);
    check("post_rst_data", bus.rsp_data, 16'h0002);
    check("post_rst_count", bus.grant_count, 1);
    bus.req_valid = 4'b0000;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
